// File: rtl/smart_commute_pkg.sv
// smart_commute_pkg: shared door FSM states and occupancy constants for the smart-commute path
// Ports: none (package).
package smart_commute_pkg;
    typedef enum logic [2:0] {IDLE, E1, E2, E3, X1, X2, X3, WAIT_CLR} door_state_t;
    localparam int BUS_CAPACITY = 30;
    localparam int OCC_W = 5;
endpackage

// File: rtl/bus_door_sensor_if.sv
// bus_door_sensor_if: door sensor bundle between beam/occupancy sources and the step consumer
// Ports: beam_out_raw, beam_in_raw, occ_count (into the sensor); step, up, reject_full,
// reject_empty, fault (out of the sensor). slave = sensor side, master = environment side.
interface bus_door_sensor_if #(parameter int OCC_W = smart_commute_pkg::OCC_W);
    logic             beam_out_raw;
    logic             beam_in_raw;
    logic [OCC_W-1:0] occ_count;
    logic             step;
    logic             up;
    logic             reject_full;
    logic             reject_empty;
    logic             fault;
    modport master (output beam_out_raw, beam_in_raw, occ_count,
                    input  step, up, reject_full, reject_empty, fault);
    modport slave  (input  beam_out_raw, beam_in_raw, occ_count,
                    output step, up, reject_full, reject_empty, fault);
endinterface

// File: rtl/beam_debounce.sv
// beam_debounce: two-flop synchroniser plus stability counter for one IR beam
// Ports: clk, reset (sync, active-high), raw (async beam, 1 = blocked), level (debounced beam).
module beam_debounce #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level
);
    localparam int CW = $clog2(DEB_CYCLES + 1);
    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done;
    // The level flips on the DEB_CYCLES-th consecutive differing sample, giving 2 + DEB_CYCLES latency.
    always_comb begin
        done    = (sync2_q != level_q) && (cnt_q == CW'(DEB_CYCLES - 1));
        cnt_d   = (sync2_q == level_q || done) ? '0 : cnt_q + 1'b1;
        level_d = done ? sync2_q : level_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end
    assign level = level_q;
endmodule

// File: rtl/bus_door_sensor.sv
// bus_door_sensor: decodes door beam-break order into gated entry/exit step pulses
// Ports: clk, reset (sync, active-high), bus (slave modport): beams and occ_count in;
// step/up event, reject_full/reject_empty pulses and fault level out.
module bus_door_sensor #(
    parameter int DEB_CYCLES = 16,
    parameter int TIMEOUT    = 50000,
    parameter int CAPACITY   = smart_commute_pkg::BUS_CAPACITY,
    parameter int OCC_W      = smart_commute_pkg::OCC_W
) (
    input logic              clk,
    input logic              reset,
    bus_door_sensor_if.slave bus
);
    import smart_commute_pkg::*;
    localparam int TW = $clog2(TIMEOUT + 1);
    logic          o, i, clr;
    door_state_t   state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          step_q, step_d, up_q, up_d;
    logic          rf_q, rf_d, re_q, re_d;
    logic          fault_q, fault_d;
    logic          tmo_hit, ent_done, ext_done, room, occupied, counting;
    beam_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_out (
        .clk(clk), .reset(reset), .raw(bus.beam_out_raw), .level(o)
    );
    beam_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_in (
        .clk(clk), .reset(reset), .raw(bus.beam_in_raw), .level(i)
    );
    always_comb begin
        clr     = !o && !i;
        // Fires on the TIMEOUT-th cycle spent in one decode state and overrides any normal move.
        tmo_hit = (state_q != IDLE) && (state_q != WAIT_CLR) && (tmo_q == TW'(TIMEOUT - 1));
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = (o && !i) ? E1 : (!o && i) ? X1 : (o && i) ? WAIT_CLR : IDLE;
            E1:      state_d = (o && i) ? E2 : clr ? IDLE : E1;
            E2:      state_d = (!o && i) ? E3 : (o && !i) ? E1 : E2;
            E3:      state_d = clr ? IDLE : (o && i) ? E2 : E3;
            X1:      state_d = (o && i) ? X2 : clr ? IDLE : X1;
            X2:      state_d = (o && !i) ? X3 : (!o && i) ? X1 : X2;
            X3:      state_d = clr ? IDLE : (o && i) ? X2 : X3;
            default: state_d = clr ? IDLE : WAIT_CLR;
        endcase
        if (tmo_hit) state_d = WAIT_CLR;
        ent_done = !tmo_hit && (state_q == E3) && clr;
        ext_done = !tmo_hit && (state_q == X3) && clr;
        room     = bus.occ_count < OCC_W'(CAPACITY);
        occupied = bus.occ_count != '0;
        step_d   = (ent_done && room) || (ext_done && occupied);
        up_d     = (ent_done && room) ? 1'b1 : (ext_done && occupied) ? 1'b0 : up_q;
        rf_d     = ent_done && !room;
        re_d     = ext_done && !occupied;
        fault_d  = tmo_hit ? 1'b1 : (state_q == WAIT_CLR && clr) ? 1'b0 : fault_q;
        counting = (state_d == state_q) && (state_q != IDLE) && (state_q != WAIT_CLR);
        tmo_d    = counting ? tmo_q + 1'b1 : '0;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            tmo_q   <= '0;
            step_q  <= 1'b0;
            up_q    <= 1'b1;
            rf_q    <= 1'b0;
            re_q    <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            step_q  <= step_d;
            up_q    <= up_d;
            rf_q    <= rf_d;
            re_q    <= re_d;
            fault_q <= fault_d;
        end
    end
    assign bus.step         = step_q;
    assign bus.up           = up_q;
    assign bus.reject_full  = rf_q;
    assign bus.reject_empty = re_q;
    assign bus.fault        = fault_q;
endmodule

// File: tb/tb_bus_door_sensor.sv
// tb_bus_door_sensor: table-driven directed checks of door decoding, gating, timeout and reset
module tb_bus_door_sensor;
    import smart_commute_pkg::*;
    typedef struct {
        logic       o;
        logic       i;
        logic [4:0] occ;
        int         n;
        int         ns;
        int         nf;
        int         ne;
        logic       up;
    } vec_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cnt_s, cnt_f, cnt_e;
    int   first;
    vec_t vecs[$];
    bus_door_sensor_if bus_if();
    bus_door_sensor #(.DEB_CYCLES(4), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset), .bus(bus_if)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic drive(input logic o, input logic i, input logic [4:0] occ);
        bus_if.beam_out_raw = o;
        bus_if.beam_in_raw  = i;
        bus_if.occ_count    = occ;
    endtask
    task automatic hold(input int n);
        for (int k = 0; k < n; k++) begin
            cyc();
            cnt_s += int'(bus_if.step);
            cnt_f += int'(bus_if.reject_full);
            cnt_e += int'(bus_if.reject_empty);
        end
    endtask
    function automatic vec_t v(input logic o, input logic i, input logic [4:0] occ, input int n,
                               input int ns, input int nf, input int ne, input logic up);
        vec_t r;
        r.o = o; r.i = i; r.occ = occ; r.n = n; r.ns = ns; r.nf = nf; r.ne = ne; r.up = up;
        return r;
    endfunction
    initial begin
        // clean entry
        vecs.push_back(v(1, 0, 5, 10, 0, 0, 0, 1));
        vecs.push_back(v(1, 1, 5, 10, 0, 0, 0, 1));
        vecs.push_back(v(0, 1, 5, 10, 0, 0, 0, 1));
        vecs.push_back(v(0, 0, 5, 10, 1, 0, 0, 1));
        // abort from E1
        vecs.push_back(v(1, 0, 5, 10, 0, 0, 0, 1));
        vecs.push_back(v(0, 0, 5, 10, 0, 0, 0, 1));
        // entry with a step back
        vecs.push_back(v(1, 0, 5, 10, 0, 0, 0, 1));
        vecs.push_back(v(1, 1, 5, 10, 0, 0, 0, 1));
        vecs.push_back(v(1, 0, 5, 10, 0, 0, 0, 1));
        vecs.push_back(v(1, 1, 5, 10, 0, 0, 0, 1));
        vecs.push_back(v(0, 1, 5, 10, 0, 0, 0, 1));
        vecs.push_back(v(0, 0, 5, 10, 1, 0, 0, 1));
        // clean exit
        vecs.push_back(v(0, 1, 5, 10, 0, 0, 0, 1));
        vecs.push_back(v(1, 1, 5, 10, 0, 0, 0, 1));
        vecs.push_back(v(1, 0, 5, 10, 0, 0, 0, 1));
        vecs.push_back(v(0, 0, 5, 10, 1, 0, 0, 0));
        // 3-cycle outer glitch in IDLE
        vecs.push_back(v(1, 0, 5, 3, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 5, 10, 0, 0, 0, 0));
        // entry while full: rejected, up stays 0
        vecs.push_back(v(1, 0, 30, 10, 0, 0, 0, 0));
        vecs.push_back(v(1, 1, 30, 10, 0, 0, 0, 0));
        vecs.push_back(v(0, 1, 30, 10, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 30, 10, 0, 1, 0, 0));
        // entry at 29 is still accepted
        vecs.push_back(v(1, 0, 29, 10, 0, 0, 0, 0));
        vecs.push_back(v(1, 1, 29, 10, 0, 0, 0, 0));
        vecs.push_back(v(0, 1, 29, 10, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 29, 10, 1, 0, 0, 1));
        // exit while empty: rejected, up stays 1
        vecs.push_back(v(0, 1, 0, 10, 0, 0, 0, 1));
        vecs.push_back(v(1, 1, 0, 10, 0, 0, 0, 1));
        vecs.push_back(v(1, 0, 0, 10, 0, 0, 0, 1));
        vecs.push_back(v(0, 0, 0, 10, 0, 0, 1, 1));
        // exit at occupancy 1 is accepted
        vecs.push_back(v(0, 1, 1, 10, 0, 0, 0, 1));
        vecs.push_back(v(1, 1, 1, 10, 0, 0, 0, 1));
        vecs.push_back(v(1, 0, 1, 10, 0, 0, 0, 1));
        vecs.push_back(v(0, 0, 1, 10, 1, 0, 0, 0));
        drive(0, 0, 5);
        repeat (3) cyc();
        chk("rst step", bus_if.step, 0);
        chk("rst up", bus_if.up, 1);
        chk("rst reject_full", bus_if.reject_full, 0);
        chk("rst reject_empty", bus_if.reject_empty, 0);
        chk("rst fault", bus_if.fault, 0);
        chk("rst state", dut.state_q, IDLE);
        reset = 1'b0;
        foreach (vecs[k]) begin
            drive(vecs[k].o, vecs[k].i, vecs[k].occ);
            cnt_s = 0; cnt_f = 0; cnt_e = 0;
            hold(vecs[k].n);
            chk($sformatf("v%0d step", k), cnt_s, vecs[k].ns);
            chk($sformatf("v%0d reject_full", k), cnt_f, vecs[k].nf);
            chk($sformatf("v%0d reject_empty", k), cnt_e, vecs[k].ne);
            chk($sformatf("v%0d up", k), bus_if.up, vecs[k].up);
            chk($sformatf("v%0d fault", k), bus_if.fault, 0);
        end
        // reset while in E3 drops the partial entry
        cnt_s = 0; cnt_f = 0; cnt_e = 0;
        drive(1, 0, 5); hold(10);
        drive(1, 1, 5); hold(10);
        drive(0, 1, 5); hold(10);
        chk("pre-reset state", dut.state_q, E3);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("mid rst state", dut.state_q, IDLE);
        chk("mid rst up", bus_if.up, 1);
        chk("mid rst step", bus_if.step, 0);
        chk("mid rst fault", bus_if.fault, 0);
        drive(0, 0, 5);
        hold(20);
        chk("post-reset step", cnt_s, 0);
        chk("post-reset rejects", cnt_f + cnt_e, 0);
        // exact completion latency from the final raw edge
        drive(1, 0, 5); hold(10);
        drive(1, 1, 5); hold(10);
        drive(0, 1, 5); hold(10);
        drive(0, 0, 5);
        first = 0;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if (bus_if.step && first == 0) first = k;
        end
        chk("entry latency", first, 7);
        chk("entry up", bus_if.up, 1);
        // timeout while stuck in E2, then recovery
        cnt_s = 0; cnt_f = 0; cnt_e = 0;
        drive(1, 0, 5); hold(10);
        drive(1, 1, 5);
        for (int k = 1; k <= 110; k++) begin
            hold(1);
            if (k == 70) chk("fault before timeout", bus_if.fault, 0);
            if (k == 71) chk("fault at timeout", bus_if.fault, 1);
            if (k == 110) chk("fault held", bus_if.fault, 1);
            if (k == 110) chk("timeout state", dut.state_q, WAIT_CLR);
        end
        drive(0, 0, 5);
        for (int k = 1; k <= 10; k++) begin
            hold(1);
            if (k == 6) chk("fault before clear", bus_if.fault, 1);
            if (k == 7) chk("fault cleared", bus_if.fault, 0);
            if (k == 7) chk("idle after clear", dut.state_q, IDLE);
        end
        chk("timeout no step", cnt_s, 0);
        chk("timeout no reject", cnt_f + cnt_e, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
